// File: rtl/binary_perceptron_if.sv
// Training/configuration bus of binary_perceptron: fit control, learning
// parameters, initial-weight load and weight/status read-back.
interface binary_perceptron_if #(
  parameter int W = 8
);
  logic                train_start;
  logic [3:0]          targets;
  logic [15:0]         max_epochs;
  logic signed [W-1:0] eta;
  logic                load_init;
  logic signed [W-1:0] w1_init;
  logic signed [W-1:0] w2_init;
  logic signed [W-1:0] b_init;
  logic signed [W-1:0] w1_o;
  logic signed [W-1:0] w2_o;
  logic signed [W-1:0] b_o;
  logic                busy;
  logic                done;
  logic                converged;
  logic [15:0]         epoch_count;

  // Register wrapper side: drives control, reads weights and status
  modport master (
    output train_start, targets, max_epochs, eta, load_init,
           w1_init, w2_init, b_init,
    input  w1_o, w2_o, b_o, busy, done, converged, epoch_count
  );

  // Perceptron side
  modport slave (
    input  train_start, targets, max_epochs, eta, load_init,
           w1_init, w2_init, b_init,
    output w1_o, w2_o, b_o, busy, done, converged, epoch_count
  );
endinterface

// File: rtl/binary_perceptron.sv
// Two-input binary perceptron with on-chip perceptron-rule training over the
// fixed 4-pattern truth table, one sample per clock.
// Optional: define BINARY_PERCEPTRON_SUM_DBG_EN to register and drive sum_dbg;
// otherwise sum_dbg is tied to zero.
module binary_perceptron #(
  parameter int W = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                x1,
  input  logic                x2,
  output logic                y,
  output logic signed [W+1:0] sum_dbg,
  binary_perceptron_if.slave  bus
);

  localparam logic signed [W-1:0] WMAX = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0] WMIN = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic signed [W-1:0] w1_q, w1_d;
  logic signed [W-1:0] w2_q, w2_d;
  logic signed [W-1:0] b_q, b_d;
  logic signed [W-1:0] eta_q, eta_d;
  logic [3:0]          tgt_q, tgt_d;
  logic [15:0]         max_ep_q, max_ep_d;
  logic [15:0]         ep_q, ep_d;
  logic [1:0]          idx_q, idx_d;
  logic                err_q, err_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                conv_q, conv_d;
  logic                y_q, y_d;

  // b + selected weights, sign-extended so the sum can never overflow
  function automatic logic signed [W+1:0] calc_sum(
    input logic                a1,
    input logic                a2,
    input logic signed [W-1:0] w1,
    input logic signed [W-1:0] w2,
    input logic signed [W-1:0] b
  );
    logic signed [W+1:0] s;
    s = {{2{b[W-1]}}, b};
    if (a1) s = s + {{2{w1[W-1]}}, w1};
    if (a2) s = s + {{2{w2[W-1]}}, w2};
    return s;
  endfunction

  // Add at W+1 bits, then clamp back into the W-bit signed range
  function automatic logic signed [W-1:0] sat_add(
    input logic signed [W-1:0] a,
    input logic signed [W:0]   d
  );
    logic signed [W:0] r;
    r = {a[W-1], a} + d;
    if (r[W] != r[W-1]) return r[W] ? WMIN : WMAX;
    return r[W-1:0];
  endfunction

  logic signed [W+1:0] s_pred;
  logic signed [W+1:0] s_tr;
  logic                pat_x1, pat_x2;
  logic                tgt_bit, yp, err_nz;
  logic signed [W:0]   eta_ext, delta;
  logic [15:0]         ep_next;
  logic                had_err;

  // Prediction path and training-sample arithmetic
  always_comb begin
    s_pred  = calc_sum(x1, x2, w1_q, w2_q, b_q);
    y_d     = (s_pred >= 0);
    pat_x1  = idx_q[1];
    pat_x2  = idx_q[0];
    s_tr    = calc_sum(pat_x1, pat_x2, w1_q, w2_q, b_q);
    yp      = (s_tr >= 0);
    tgt_bit = tgt_q[idx_q];
    err_nz  = (tgt_bit != yp);
    eta_ext = {eta_q[W-1], eta_q};
    // err is +1 when target is 1 (prediction 0), -1 otherwise
    delta   = tgt_bit ? eta_ext : -eta_ext;
    ep_next = (ep_q == 16'hFFFF) ? ep_q : ep_q + 16'd1;
    had_err = err_q | err_nz;
  end

  // Control FSM next-state and weight update
  always_comb begin
    state_d  = state_q;
    w1_d     = w1_q;
    w2_d     = w2_q;
    b_d      = b_q;
    eta_d    = eta_q;
    tgt_d    = tgt_q;
    max_ep_d = max_ep_q;
    ep_d     = ep_q;
    idx_d    = idx_q;
    err_d    = err_q;
    busy_d   = busy_q;
    done_d   = done_q;
    conv_d   = conv_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.load_init) begin
          w1_d    = bus.w1_init;
          w2_d    = bus.w2_init;
          b_d     = bus.b_init;
          done_d  = 1'b0;
          conv_d  = 1'b0;
          state_d = ST_IDLE;
        end else if (bus.train_start) begin
          tgt_d    = bus.targets;
          eta_d    = bus.eta;
          max_ep_d = (bus.max_epochs == 16'd0) ? 16'd1 : bus.max_epochs;
          done_d   = 1'b0;
          conv_d   = 1'b0;
          ep_d     = '0;
          idx_d    = '0;
          err_d    = 1'b0;
          busy_d   = 1'b1;
          state_d  = ST_TRAIN;
        end
      end
      ST_TRAIN: begin
        if (err_nz) begin
          b_d = sat_add(b_q, delta);
          if (pat_x1) w1_d = sat_add(w1_q, delta);
          if (pat_x2) w2_d = sat_add(w2_q, delta);
          err_d = 1'b1;
        end
        if (idx_q == 2'd3) begin
          ep_d = ep_next;
          if (!had_err) begin
            conv_d  = 1'b1;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = ST_DONE;
          end else if (ep_next >= max_ep_q) begin
            conv_d  = 1'b0;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = ST_DONE;
          end else begin
            err_d = 1'b0;
            idx_d = '0;
          end
        end else begin
          idx_d = idx_q + 2'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, weights, status and prediction registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      w1_q     <= '0;
      w2_q     <= '0;
      b_q      <= '0;
      eta_q    <= '0;
      tgt_q    <= '0;
      max_ep_q <= '0;
      ep_q     <= '0;
      idx_q    <= '0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      conv_q   <= 1'b0;
      y_q      <= 1'b0;
    end else begin
      state_q  <= state_d;
      w1_q     <= w1_d;
      w2_q     <= w2_d;
      b_q      <= b_d;
      eta_q    <= eta_d;
      tgt_q    <= tgt_d;
      max_ep_q <= max_ep_d;
      ep_q     <= ep_d;
      idx_q    <= idx_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      conv_q   <= conv_d;
      y_q      <= y_d;
    end
  end

`ifdef BINARY_PERCEPTRON_SUM_DBG_EN
  logic signed [W+1:0] sum_dbg_q, sum_dbg_d;

  // Debug copy of the sum behind y
  always_comb sum_dbg_d = s_pred;

  // Debug sum register
  always_ff @(posedge clk) begin
    if (reset) sum_dbg_q <= '0;
    else       sum_dbg_q <= sum_dbg_d;
  end

  assign sum_dbg = sum_dbg_q;
`else
  assign sum_dbg = '0;
`endif

  assign y               = y_q;
  assign bus.w1_o        = w1_q;
  assign bus.w2_o        = w2_q;
  assign bus.b_o         = b_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.converged   = conv_q;
  assign bus.epoch_count = ep_q;

endmodule

// File: tb/tb_binary_perceptron.sv
// Scoreboard bench for binary_perceptron: stimulus pushes expectations,
// negedge monitor pops and compares.
module tb_binary_perceptron;
  localparam int W = 8;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic                x1 = 1'b0;
  logic                x2 = 1'b0;
  logic                y;
  logic signed [W+1:0] sum_dbg;

  binary_perceptron_if #(.W(W)) bus ();

  binary_perceptron #(.W(W)) dut (
    .clk     (clk),
    .reset   (reset),
    .x1      (x1),
    .x2      (x2),
    .y       (y),
    .sum_dbg (sum_dbg),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    string name;
    bit    chk_pred;
    bit    exp_y;
    int    exp_sum;
    bit    chk_flags;
    bit    exp_busy;
    bit    exp_done;
    bit    exp_conv;
    int    exp_ep;
    bit    chk_w;
    int    exp_w1;
    int    exp_w2;
    int    exp_b;
  } probe_t;

  typedef struct {
    string name;
    int    ep;
    bit    conv;
    int    w1;
    int    w2;
    int    b;
    int    cyc;
  } fit_rec_t;

  typedef struct {
    int w1;
    int w2;
    int b;
    int ep;
    bit conv;
  } fit_t;

  probe_t   probe_q[$];
  fit_rec_t train_q[$];
  int       checks = 0;
  int       errors = 0;
  int       cyc = 0;
  logic     probe_req = 1'b0;
  logic     probe_d = 1'b0;
  logic     done_prev = 1'b0;

  // Reference state of the DUT as seen from outside
  int m_w1 = 0, m_w2 = 0, m_b = 0, m_ep = 0;
  bit m_conv = 0, m_done = 0, m_busy = 0;
  fit_t pend;

  function automatic void chk(string nm, int act, int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s: actual %0d, expected %0d", nm, act, exp_v);
    end
  endfunction

  function automatic int clamp(int v);
    if (v > 127) return 127;
    if (v < -128) return -128;
    return v;
  endfunction

  function automatic int sum_exp(int s);
`ifdef BINARY_PERCEPTRON_SUM_DBG_EN
    return s;
`else
    return 0;
`endif
  endfunction

  // Perceptron learning rule over the 4-pattern table, plain integer math
  function automatic fit_t model_fit(int w1, int w2, int b, bit [3:0] t, int eta, int maxep);
    fit_t r;
    int   lim;
    bit   any;
    int   s, e;
    bit   a1, a2;
    lim    = (maxep == 0) ? 1 : maxep;
    r.ep   = 0;
    r.conv = 0;
    while (1) begin
      any = 0;
      for (int unsigned p = 0; p < 4; p++) begin
        a1 = (p >= 2);
        a2 = (p % 2 == 1);
        s  = b + (a1 ? w1 : 0) + (a2 ? w2 : 0);
        e  = int'(t[p]) - ((s >= 0) ? 1 : 0);
        if (e != 0) begin
          b = clamp(b + e * eta);
          if (a1) w1 = clamp(w1 + e * eta);
          if (a2) w2 = clamp(w2 + e * eta);
          any = 1;
        end
      end
      if (r.ep < 65535) r.ep++;
      if (!any) begin
        r.conv = 1;
        break;
      end
      if (r.ep >= lim) break;
    end
    r.w1 = w1;
    r.w2 = w2;
    r.b  = b;
    return r;
  endfunction

  function automatic probe_t blank(string nm);
    probe_t p;
    p.name = nm;
    p.chk_pred = 0; p.exp_y = 0; p.exp_sum = 0;
    p.chk_flags = 0; p.exp_busy = 0; p.exp_done = 0; p.exp_conv = 0; p.exp_ep = 0;
    p.chk_w = 0; p.exp_w1 = 0; p.exp_w2 = 0; p.exp_b = 0;
    return p;
  endfunction

  always @(posedge clk) begin
    cyc     <= cyc + 1;
    probe_d <= probe_req;
  end

  // Monitor: probes one cycle after they were issued, fit results on done rise
  always @(negedge clk) begin
    probe_t   p;
    fit_rec_t f;
    if (probe_d) begin
      if (probe_q.size() == 0) chk("probe_underflow", 1, 0);
      else begin
        p = probe_q.pop_front();
        if (p.chk_pred) begin
          chk({p.name, ".y"}, int'(y), int'(p.exp_y));
          chk({p.name, ".sum_dbg"}, int'(sum_dbg), p.exp_sum);
        end
        if (p.chk_flags) begin
          chk({p.name, ".busy"}, int'(bus.busy), int'(p.exp_busy));
          chk({p.name, ".done"}, int'(bus.done), int'(p.exp_done));
          chk({p.name, ".converged"}, int'(bus.converged), int'(p.exp_conv));
          chk({p.name, ".epoch_count"}, int'(bus.epoch_count), p.exp_ep);
        end
        if (p.chk_w) begin
          chk({p.name, ".w1"}, int'(bus.w1_o), p.exp_w1);
          chk({p.name, ".w2"}, int'(bus.w2_o), p.exp_w2);
          chk({p.name, ".b"}, int'(bus.b_o), p.exp_b);
        end
      end
    end
    if (bus.done && !done_prev) begin
      if (train_q.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        f = train_q.pop_front();
        chk({f.name, ".done_cycle"}, cyc, f.cyc);
        chk({f.name, ".busy"}, int'(bus.busy), 0);
        chk({f.name, ".epoch_count"}, int'(bus.epoch_count), f.ep);
        chk({f.name, ".converged"}, int'(bus.converged), int'(f.conv));
        chk({f.name, ".w1"}, int'(bus.w1_o), f.w1);
        chk({f.name, ".w2"}, int'(bus.w2_o), f.w2);
        chk({f.name, ".b"}, int'(bus.b_o), f.b);
      end
    end
    done_prev = bus.done;
  end

  task automatic step();
    @(posedge clk);
    #1;
    bus.train_start = 1'b0;
    bus.load_init   = 1'b0;
    probe_req       = 1'b0;
  endtask

  task automatic probe_pred(string nm, bit a1, bit a2);
    probe_t p;
    int     s;
    p = blank(nm);
    s = m_b + (a1 ? m_w1 : 0) + (a2 ? m_w2 : 0);
    p.chk_pred = 1;
    p.exp_y    = (s >= 0);
    p.exp_sum  = sum_exp(s);
    x1 = a1;
    x2 = a2;
    probe_q.push_back(p);
    probe_req = 1'b1;
    step();
  endtask

  task automatic probe_state(string nm, bit with_w, bit reset_pred);
    probe_t p;
    p = blank(nm);
    p.chk_flags = 1;
    p.exp_busy  = m_busy;
    p.exp_done  = m_done;
    p.exp_conv  = m_conv;
    p.exp_ep    = m_ep;
    p.chk_w     = with_w;
    p.exp_w1    = m_w1;
    p.exp_w2    = m_w2;
    p.exp_b     = m_b;
    p.chk_pred  = reset_pred;
    probe_q.push_back(p);
    probe_req = 1'b1;
    step();
  endtask

  task automatic do_load(int w1, int w2, int b);
    bus.w1_init   = W'(w1);
    bus.w2_init   = W'(w2);
    bus.b_init    = W'(b);
    bus.load_init = 1'b1;
    m_w1 = w1; m_w2 = w2; m_b = b;
    m_done = 0; m_conv = 0;
    step();
  endtask

  task automatic start_fit(string nm, bit [3:0] t, int eta, int maxep, bit expect_done);
    fit_rec_t f;
    bus.targets     = t;
    bus.eta         = W'(eta);
    bus.max_epochs  = 16'(maxep);
    bus.train_start = 1'b1;
    pend = model_fit(m_w1, m_w2, m_b, t, eta, maxep);
    if (expect_done) begin
      f.name = nm;
      f.ep   = pend.ep;
      f.conv = pend.conv;
      f.w1   = pend.w1;
      f.w2   = pend.w2;
      f.b    = pend.b;
      f.cyc  = cyc + 1 + 4 * pend.ep;
      train_q.push_back(f);
    end
    m_busy = 1; m_done = 0; m_conv = 0; m_ep = 0;
    step();
  endtask

  task automatic wait_done(string nm);
    int n;
    n = 0;
    while (!bus.done && n < 400) begin
      step();
      n++;
    end
    if (!bus.done) chk({nm, ".done_timeout"}, 0, 1);
    m_w1 = pend.w1; m_w2 = pend.w2; m_b = pend.b;
    m_ep = pend.ep; m_conv = pend.conv;
    m_done = 1; m_busy = 0;
  endtask

  task automatic truth_table(string nm);
    for (int unsigned i = 0; i < 4; i++) probe_pred(nm, i >= 2, i % 2 == 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, actual timeout, required completion");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end

  initial begin
    bit [3:0] fn[5];
    string    fn_name[5];
    fn[0] = 4'b1000; fn_name[0] = "AND";
    fn[1] = 4'b1110; fn_name[1] = "OR";
    fn[2] = 4'b0111; fn_name[2] = "NAND";
    fn[3] = 4'b0001; fn_name[3] = "NOR";
    fn[4] = 4'b0110; fn_name[4] = "XOR";

    bus.train_start = 1'b0;
    bus.load_init   = 1'b0;
    bus.targets     = '0;
    bus.max_epochs  = '0;
    bus.eta         = '0;
    bus.w1_init     = '0;
    bus.w2_init     = '0;
    bus.b_init      = '0;

    // Reset held five cycles, outputs checked on the last one
    reset = 1'b1;
    repeat (4) step();
    probe_state("reset", 1, 1);
    reset = 1'b0;
    probe_pred("post_reset_00", 0, 0);

    // Named Boolean functions from zero weights
    for (int unsigned k = 0; k < 5; k++) begin
      do_load(0, 0, 0);
      start_fit(fn_name[k], fn[k], 16, 16, 1);
      wait_done(fn_name[k]);
      truth_table(fn_name[k]);
      probe_state({fn_name[k], "_status"}, 1, 0);
    end

    // train_start while busy is ignored
    do_load(0, 0, 0);
    start_fit("busy_retrigger", 4'b1000, 16, 16, 1);
    repeat (2) step();
    bus.targets     = 4'b0110;
    bus.eta         = W'(-5);
    bus.train_start = 1'b1;
    probe_state("busy_mid", 0, 0);
    wait_done("busy_retrigger");
    truth_table("busy_retrigger");

    // load_init and train_start together: load only
    bus.w1_init     = W'(5);
    bus.w2_init     = W'(-3);
    bus.b_init      = W'(7);
    bus.load_init   = 1'b1;
    bus.targets     = 4'b0110;
    bus.train_start = 1'b1;
    m_w1 = 5; m_w2 = -3; m_b = 7; m_done = 0; m_conv = 0;
    probe_state("load_and_start", 1, 0);
    probe_state("load_and_start_after", 1, 0);

    // max_epochs of 0 behaves as 1
    do_load(0, 0, 0);
    start_fit("xor_max0", 4'b0110, 16, 0, 1);
    wait_done("xor_max0");
    probe_state("xor_max0_status", 1, 0);

    // Reset during a fit aborts it, then a fresh fit completes
    do_load(0, 0, 0);
    start_fit("aborted", 4'b0110, 16, 16, 0);
    repeat (5) step();
    reset = 1'b1;
    m_w1 = 0; m_w2 = 0; m_b = 0; m_ep = 0; m_conv = 0; m_done = 0; m_busy = 0;
    probe_state("mid_fit_reset", 1, 1);
    reset = 1'b0;
    start_fit("after_reset_and", 4'b1000, 16, 16, 1);
    wait_done("after_reset_and");
    truth_table("after_reset_and");

    // Saturation at both rails
    do_load(127, 0, 127);
    start_fit("sat_pos", 4'b0000, -128, 16, 1);
    wait_done("sat_pos");
    truth_table("sat_pos");
    do_load(-128, 0, -128);
    start_fit("sat_neg", 4'b1111, -128, 16, 1);
    wait_done("sat_neg");
    truth_table("sat_neg");

    // Randomised fits from random initial weights
    for (int unsigned r = 0; r < 8; r++) begin
      do_load(int'($urandom_range(255)) - 128, int'($urandom_range(255)) - 128,
              int'($urandom_range(255)) - 128);
      start_fit("rand_fit", 4'($urandom_range(15)), int'($urandom_range(64)) - 32,
                int'($urandom_range(12)), 1);
      wait_done("rand_fit");
      for (int unsigned j = 0; j < 6; j++)
        probe_pred("rand_pred", 1'($urandom_range(1)), 1'($urandom_range(1)));
      probe_state("rand_status", 1, 0);
    end

    repeat (3) step();
    chk("probe_queue_drained", probe_q.size(), 0);
    chk("fit_queue_drained", train_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/binary_perceptron.md
Name: binary_perceptron

Overview:
Two-input binary perceptron with on-chip training.
- Prediction: registered step output y = step(b + w1·x1 + w2·x2).
- Fit: classic perceptron learning over the fixed 4-pattern truth table of a 2-input Boolean function, one sample per clock.
- Sits behind an AXI-lite register wrapper that drives targets/eta/epochs and reads back weights and status.

Parameters:
W  8  signed weight/bias/eta width, Q(W-4).4 fixed point (16 = 1.0 at W=8)

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
x1  in  1  prediction input 1
x2  in  1  prediction input 2
y  out  1  registered prediction
sum_dbg  out  W+2 signed  registered weighted sum behind y
train_start  in  1  one-cycle pulse: start fit
targets  in  4  {t11,t10,t01,t00}; bit index = {x1,x2}
max_epochs  in  16  epoch limit
eta  in  W signed  learning rate
load_init  in  1  one-cycle pulse: load initial weights
w1_init, w2_init, b_init  in  W signed each  initial weights
w1_o, w2_o, b_o  out  W signed each  current weights
busy  out  1  training in progress
done  out  1  training finished (sticky)
converged  out  1  last fit ended with a zero-error epoch
epoch_count  out  16  epochs completed in current/last fit

Behaviour:
- Reset (sync, active-high):
  - weights, y, sum_dbg, busy, done, converged and epoch_count all 0.
  - State goes to IDLE; reset mid-training aborts the fit.
- Sum: s = b + (x1 ? w1 : 0) + (x2 ? w2 : 0), computed sign-extended to W+2 bits, no overflow. Step is 1 iff s >= 0.
- Prediction path, every cycle in every state:
  - sum_dbg <= s(x1, x2, current weights).
  - y <= (s >= 0).
  - Latency is 1 clock from x1/x2 to y/sum_dbg.
- States IDLE, TRAIN, DONE. w1_o/w2_o/b_o are the live weight registers.
- load_init:
  - In IDLE or DONE: load the weights from w1_init/w2_init/b_init, clear done and converged, go to IDLE.
  - Ignored while busy.
  - If asserted in the same cycle as train_start, load_init wins and train_start is ignored.
- train_start in IDLE or DONE:
  - Latch targets, eta and max_epochs (a max_epochs value of 0 is treated as 1).
  - Clear done, converged, epoch_count and the sample index and error flag.
  - Set busy=1 and go to TRAIN. Weights are not reset.
  - Ignored while busy.
- TRAIN, one sample per cycle, idx 0..3 = {x1,x2} = 00, 01, 10, 11:
  - Compute yp = step(s(idx)) with the current weights; err = t[idx] - yp, in {-1, 0, +1}.
  - If err ≠ 0: b += err·eta; w1 += err·eta if x1 = 1; w2 += err·eta if x2 = 1. Each add is done at W+1 bits and saturates to [-2^(W-1), 2^(W-1)-1]. Mark that the epoch had an error.
  - At idx=3 (including that sample's update):
    - epoch_count++, saturating at 0xFFFF.
    - No error in the epoch → converged=1, done=1, busy=0, go to DONE.
    - Otherwise, if the new epoch_count ≥ latched max_epochs → converged=0, done=1, busy=0, go to DONE.
    - Otherwise clear the error flag and set idx=0.
- DONE: done, converged, epoch_count and weights hold until train_start, load_init or reset.
- Latency: done rises 4·N cycles after the train_start edge, where N = final epoch_count.

Optional Feature:
BINARY_PERCEPTRON_SUM_DBG_EN
- Defined: sum_dbg is driven as specified.
- Undefined: sum_dbg is tied to 0 and its register is removed. y is unaffected.

Test Plan:
- reset held 5 cycles → all outputs 0; after release with x1=x2=0, next cycle y=1, sum_dbg=0.
- AND: load_init 0/0/0, train_start with targets=4'b1000, eta=16, max_epochs=16 → done=1, converged=1, epoch_count=6, w1=32, w2=16, b=-48; predict 00/01/10/11 → y=0,0,0,1 with sum=-48,-32,-16,0.
- OR=1110, NAND=0111, NOR=0001, each from zero weights with eta=16 → converged=1, epoch_count ≤ 16, truth table reproduced one cycle after each input change.
- XOR=0110 from zero weights, max_epochs=16 → done=1, converged=0, epoch_count=16, busy=0.
- Edge cases:
  - train_start while busy → ignored.
  - load_init and train_start in the same cycle → only the load occurs, busy stays 0.
  - max_epochs=0 with XOR → done after 4 cycles, epoch_count=1.
- reset asserted mid-fit → next cycle busy=0, done=0, weights=0; a new fit then completes normally.
- Saturation: load w1=127, b=127, train targets=0000 with eta=-128 → no wrap past 127 or -128.
